// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter slice.
// Holds the VRAM geometry (word address width, pixels per word, pixel width),
// the packed VRAM word type, the starvation limit default, and the
// arbitration grant encoding used by the top-level arbiter.
package vram_pkg;

    localparam int ADDR_W       = 17;
    localparam int PIX_N        = 6;
    localparam int PIX_W        = 8;
    localparam int STARVE_LIMIT = 4;

    typedef logic [PIX_N-1:0][7:0] vram_word_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VGA,
        GNT_CPU
    } grant_t;

endpackage

// File: rtl/vga_word_cache.sv
// One-word cache in front of VRAM for the VGA painter.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   vga_en       - painter is inside the active window
//   vga_addr     - painter word address
//   fill_issue   - the arbiter granted a VGA read this cycle
//   cpu_wr       - the arbiter granted a CPU write this cycle
//   cpu_addr     - CPU word address (used for coherence)
//   mem_rdata    - VRAM read data (valid the cycle after the address)
//   vga_need     - cache wants a VRAM slot for vga_addr
//   vga_stale    - painter is active and the cache does not hold vga_addr
//   vga_word     - cached word presented to the painter
module vga_word_cache #(
    parameter int ADDR_W = vram_pkg::ADDR_W,
    parameter int WORD_W = vram_pkg::PIX_N * vram_pkg::PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_en,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              fill_issue,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              vga_need,
    output logic              vga_stale,
    output logic [WORD_W-1:0] vga_word
);

    import vram_pkg::*;

    logic              valid;
    logic              fill_pending;
    logic [ADDR_W-1:0] tag;

    logic hit;
    logic fill_inflight;
    logic invalidate;
    logic fill_land;

    // The tag always names the most recently issued fill, so a pending fill
    // for the painter's address means "wait, do not ask again".
    always_comb begin
        hit           = valid && (tag == vga_addr);
        fill_inflight = fill_pending && (tag == vga_addr);
        vga_need      = vga_en && !hit && !fill_inflight;
        vga_stale     = vga_en && !hit;
        invalidate    = cpu_wr && (cpu_addr == tag) && (valid || fill_pending);
        fill_land     = fill_pending && !invalidate;
    end

    // Issuing a fill retags the cache, so valid drops immediately; a fill
    // that lands in the same edge as a new issue belongs to the old tag and
    // must not mark the new tag valid. Invalidation beats a landing fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            fill_pending <= 1'b0;
            tag          <= '0;
            vga_word     <= '0;
        end else begin
            fill_pending <= fill_issue;
            if (fill_issue) begin
                tag <= vga_addr;
            end
            if (fill_land) begin
                vga_word <= mem_rdata;
            end
            if (invalidate || fill_issue) begin
                valid <= 1'b0;
            end else if (fill_land) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter sharing the single-port synchronous-read VRAM between the VGA
// painter (cached, deadline-critical) and the vector CPU load/store port.
// Ports:
//   clk, rst_n                 - system clock, asynchronous active-low reset
//   vga_en_i, vga_addr_i       - painter window flag and word address
//   vga_word_o, vga_stale_o    - cached word and "cache misses painter" flag
//   cpu_req_i, cpu_we_i        - CPU request (held until granted), write flag
//   cpu_addr_i, cpu_wdata_i    - CPU word address and write data
//   cpu_gnt_o                  - CPU request accepted this cycle
//   cpu_rvalid_o, cpu_rdata_o  - CPU read response, one cycle after grant
//   mem_addr_o, mem_we_o       - VRAM address and write enable
//   mem_wdata_o, mem_rdata_i   - VRAM write data and read data
module vram_arbiter #(
    parameter int ADDR_W       = vram_pkg::ADDR_W,
    parameter int PIX_N        = vram_pkg::PIX_N,
    parameter int STARVE_LIMIT = vram_pkg::STARVE_LIMIT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            vga_en_i,
    input  logic [ADDR_W-1:0]               vga_addr_i,
    output logic [PIX_N*vram_pkg::PIX_W-1:0] vga_word_o,
    output logic                            vga_stale_o,
    input  logic                            cpu_req_i,
    input  logic                            cpu_we_i,
    input  logic [ADDR_W-1:0]               cpu_addr_i,
    input  logic [PIX_N*vram_pkg::PIX_W-1:0] cpu_wdata_i,
    output logic                            cpu_gnt_o,
    output logic                            cpu_rvalid_o,
    output logic [PIX_N*vram_pkg::PIX_W-1:0] cpu_rdata_o,
    output logic [ADDR_W-1:0]               mem_addr_o,
    output logic                            mem_we_o,
    output logic [PIX_N*vram_pkg::PIX_W-1:0] mem_wdata_o,
    input  logic [PIX_N*vram_pkg::PIX_W-1:0] mem_rdata_i
);

    import vram_pkg::*;

    localparam int WORD_W = PIX_N * PIX_W;
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

    grant_t             grant;
    logic               vga_need;
    logic               cpu_wr;
    logic               rd_pending;
    logic [SCNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0]  addr_q;

    vga_word_cache #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_en     (vga_en_i),
        .vga_addr   (vga_addr_i),
        .fill_issue (grant == GNT_VGA),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr_i),
        .mem_rdata  (mem_rdata_i),
        .vga_need   (vga_need),
        .vga_stale  (vga_stale_o),
        .vga_word   (vga_word_o)
    );

    // A starved CPU request overrides the painter once; otherwise the
    // painter's misses come first and the CPU takes every spare slot.
    always_comb begin
        grant = GNT_NONE;
        if (cpu_req_i && (starve_cnt == STARVE_MAX)) begin
            grant = GNT_CPU;
        end else if (vga_need) begin
            grant = GNT_VGA;
        end else if (cpu_req_i) begin
            grant = GNT_CPU;
        end
    end

    // Idle cycles keep the previous VRAM address to avoid needless toggling.
    always_comb begin
        mem_addr_o = addr_q;
        mem_we_o   = 1'b0;
        cpu_gnt_o  = 1'b0;
        case (grant)
            GNT_VGA: begin
                mem_addr_o = vga_addr_i;
            end
            GNT_CPU: begin
                mem_addr_o = cpu_addr_i;
                mem_we_o   = cpu_we_i;
                cpu_gnt_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cpu_wr       = (grant == GNT_CPU) && cpu_we_i;
    assign mem_wdata_o  = cpu_wdata_i;
    assign cpu_rdata_o  = mem_rdata_i;
    assign cpu_rvalid_o = rd_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            rd_pending <= 1'b0;
        end else begin
            addr_q     <= mem_addr_o;
            rd_pending <= cpu_gnt_o && !cpu_we_i;
        end
    end

    // Counts consecutive denied cycles of a pending request, saturating so
    // the forced slot stays armed until the CPU is actually served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (cpu_req_i && !cpu_gnt_o) begin
            if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + SCNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int AW    = 17;
    localparam int WW    = 48;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_en_i = 1'b0;
    logic [AW-1:0] vga_addr_i = '0;
    logic [WW-1:0] vga_word_o;
    logic          vga_stale_o;
    logic          cpu_req_i = 1'b0;
    logic          cpu_we_i = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic [WW-1:0] cpu_wdata_i = '0;
    logic          cpu_gnt_o;
    logic          cpu_rvalid_o;
    logic [WW-1:0] cpu_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [WW-1:0] mem_wdata_o;
    logic [WW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W       (AW),
        .PIX_N        (6),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_en_i     (vga_en_i),
        .vga_addr_i   (vga_addr_i),
        .vga_word_o   (vga_word_o),
        .vga_stale_o  (vga_stale_o),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_gnt_o    (cpu_gnt_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Default VRAM content for any word not yet written.
    function automatic logic [WW-1:0] pat(input logic [AW-1:0] a);
        return {7'h15, a, 7'h2A, ~a};
    endfunction

    // VRAM macro stand-in, driven by the DUT's memory pins.
    logic [WW-1:0] env_ram [256];
    bit            env_wr  [256];
    logic          tb_load = 1'b0;
    logic [7:0]    tb_load_addr = '0;
    logic [WW-1:0] tb_load_data = '0;

    function automatic logic [WW-1:0] env_rd(input logic [AW-1:0] a);
        return env_wr[a[7:0]] ? env_ram[a[7:0]] : pat(a);
    endfunction

    always @(posedge clk) begin
        mem_rdata_i <= env_rd(mem_addr_o);
        if (tb_load) begin
            env_ram[tb_load_addr] <= tb_load_data;
            env_wr[tb_load_addr]  <= 1'b1;
        end else if (mem_we_o) begin
            env_ram[mem_addr_o[7:0]] <= mem_wdata_o;
            env_wr[mem_addr_o[7:0]]  <= 1'b1;
        end
    end

    // Reference model: expected VRAM contents, outstanding one-cycle
    // transfers, and the painter's view of the cached word.
    typedef struct {
        bit            vga;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } xfer_t;

    logic [WW-1:0] ref_ram [256];
    bit            ref_wr  [256];
    xfer_t         inflight[$];
    bit            c_valid;
    logic [AW-1:0] c_tag;
    logic [WW-1:0] c_word;
    int            denied;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] m_addr;
    int            owner;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [WW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a[7:0]] ? ref_ram[a[7:0]] : pat(a);
    endfunction

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        inflight.delete();
        c_valid   = 1'b0;
        c_tag     = '0;
        c_word    = '0;
        denied    = 0;
        last_addr = '0;
        owner     = 0;
    endtask

    // Decide who owns this cycle from the priority rules and compare outputs.
    task automatic checkOutput();
        bit            hit;
        bit            busy;
        bit            need;
        bit            rd_due;
        logic [WW-1:0] rd_data;
        hit     = c_valid && (c_tag == vga_addr_i);
        busy    = 1'b0;
        rd_due  = 1'b0;
        rd_data = '0;
        foreach (inflight[i]) begin
            if (inflight[i].vga && inflight[i].addr == vga_addr_i) busy = 1'b1;
            if (!inflight[i].vga) begin
                rd_due  = 1'b1;
                rd_data = inflight[i].data;
            end
        end
        need = vga_en_i && !hit && !busy;
        if (cpu_req_i && denied >= LIMIT) owner = 2;
        else if (need)                    owner = 1;
        else if (cpu_req_i)               owner = 2;
        else                              owner = 0;
        m_addr = (owner == 1) ? vga_addr_i : (owner == 2) ? cpu_addr_i : last_addr;
        compare("gnt",      cpu_gnt_o,    owner == 2);
        compare("mem_we",   mem_we_o,     owner == 2 && cpu_we_i);
        compare("mem_addr", mem_addr_o,   m_addr);
        compare("stale",    vga_stale_o,  vga_en_i && !hit);
        compare("vga_word", vga_word_o,   c_word);
        compare("rvalid",   cpu_rvalid_o, rd_due);
        if (rd_due) compare("rdata", cpu_rdata_o, rd_data);
        if (owner == 2 && cpu_we_i) compare("wdata", mem_wdata_o, cpu_wdata_i);
    endtask

    // Advance the model across the clock edge that ends the current cycle.
    task automatic commitModel();
        xfer_t landing[$];
        xfer_t x;
        bit    inval;
        bit    fill_live;
        landing = inflight;
        inflight.delete();
        inval = 1'b0;
        fill_live = 1'b0;
        foreach (landing[i]) if (landing[i].vga) fill_live = 1'b1;
        if (owner == 1) begin
            x.vga  = 1'b1;
            x.addr = vga_addr_i;
            x.data = ref_rd(vga_addr_i);
            inflight.push_back(x);
            c_tag   = vga_addr_i;
            c_valid = 1'b0;
        end else if (owner == 2) begin
            if (cpu_we_i) begin
                inval = (cpu_addr_i == c_tag) && (c_valid || fill_live);
                ref_ram[cpu_addr_i[7:0]] = cpu_wdata_i;
                ref_wr[cpu_addr_i[7:0]]  = 1'b1;
            end else begin
                x.vga  = 1'b0;
                x.addr = cpu_addr_i;
                x.data = ref_rd(cpu_addr_i);
                inflight.push_back(x);
            end
        end
        foreach (landing[i]) begin
            if (landing[i].vga && !inval) begin
                c_word  = landing[i].data;
                c_valid = (landing[i].addr == c_tag);
            end
        end
        if (inval) c_valid = 1'b0;
        if (cpu_req_i && owner != 2) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
        else                          denied = 0;
        last_addr = m_addr;
    endtask

    task automatic applyStimulus(input logic en, input logic [AW-1:0] va, input logic req,
                                 input logic we, input logic [AW-1:0] ca, input logic [WW-1:0] wd);
        vga_en_i    = en;
        vga_addr_i  = va;
        cpu_req_i   = req;
        cpu_we_i    = we;
        cpu_addr_i  = ca;
        cpu_wdata_i = wd;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        commitModel();
        #1;
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        vga_en_i    = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        resetModel();
        @(negedge clk);
        compare("rst_gnt",      cpu_gnt_o,    1'b0);
        compare("rst_rvalid",   cpu_rvalid_o, 1'b0);
        compare("rst_mem_we",   mem_we_o,     1'b0);
        compare("rst_mem_addr", mem_addr_o,   '0);
        compare("rst_vga_word", vga_word_o,   '0);
        compare("rst_stale",    vga_stale_o,  1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return 17'h00010;
            1:       return 17'h00011;
            2:       return 17'h00012;
            3:       return 17'h00020;
            default: return 17'h1FF13;
        endcase
    endfunction

    initial begin
        logic [AW-1:0] v_addr;
        logic          v_en;
        logic          r_req;
        logic          r_we;
        logic [AW-1:0] r_addr;
        logic [WW-1:0] r_wd;

        foreach (ref_wr[i]) ref_wr[i] = 1'b0;
        resetModel();

        // Preload RAM[0x10] in both the VRAM stand-in and the model.
        tb_load      = 1'b1;
        tb_load_addr = 8'h10;
        tb_load_data = 48'h010203040506;
        ref_ram[8'h10] = 48'h010203040506;
        ref_wr[8'h10]  = 1'b1;
        @(posedge clk);
        #1;
        tb_load = 1'b0;
        doReset();

        $display("[TB] phase: cold fetch");
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        compare("t1_fetch_addr", mem_addr_o, 17'h10);
        endCycle();
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        endCycle();
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        compare("t1_word", vga_word_o, 48'h010203040506);
        endCycle();

        $display("[TB] phase: cpu read on cached painter");
        applyStimulus(1, 17'h10, 1, 0, 17'h20, '0);
        compare("t2_gnt", cpu_gnt_o, 1'b1);
        endCycle();
        applyStimulus(1, 17'h10, 0, 0, 17'h20, '0);
        compare("t2_rvalid", cpu_rvalid_o, 1'b1);
        compare("t2_rdata", cpu_rdata_o, pat(17'h20));
        endCycle();

        $display("[TB] phase: starvation");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 17'(48 + k), 1, 0, 17'h40, '0);
            compare("t3_gnt", cpu_gnt_o, k == 4);
            compare("t3_stale", vga_stale_o, 1'b1);
            endCycle();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 17'h34, 0, 0, '0, '0);
            compare("t3_retry_stale", vga_stale_o, k < 2);
            endCycle();
        end

        $display("[TB] phase: write to cached tag");
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        endCycle();
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        endCycle();
        applyStimulus(1, 17'h10, 1, 1, 17'h10, 48'hAABBCCDDEEFF);
        compare("t4_wr_gnt", cpu_gnt_o, 1'b1);
        compare("t4_wr_we", mem_we_o, 1'b1);
        endCycle();
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        compare("t4_refetch_addr", mem_addr_o, 17'h10);
        compare("t4_refetch_stale", vga_stale_o, 1'b1);
        endCycle();
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        endCycle();
        applyStimulus(1, 17'h10, 0, 0, '0, '0);
        compare("t4_word", vga_word_o, 48'hAABBCCDDEEFF);
        endCycle();

        $display("[TB] phase: write while fill lands");
        applyStimulus(1, 17'h50, 0, 0, '0, '0);
        endCycle();
        applyStimulus(1, 17'h50, 1, 1, 17'h50, 48'h111111222222);
        compare("t5_wr_gnt", cpu_gnt_o, 1'b1);
        endCycle();
        applyStimulus(1, 17'h50, 0, 0, '0, '0);
        compare("t5_stale", vga_stale_o, 1'b1);
        compare("t5_refetch_addr", mem_addr_o, 17'h50);
        endCycle();
        applyStimulus(1, 17'h50, 0, 0, '0, '0);
        endCycle();
        applyStimulus(1, 17'h50, 0, 0, '0, '0);
        compare("t5_word", vga_word_o, 48'h111111222222);
        endCycle();

        $display("[TB] phase: reset during cpu read");
        applyStimulus(1, 17'h50, 1, 0, 17'h20, '0);
        compare("t6_gnt", cpu_gnt_o, 1'b1);
        endCycle();
        doReset();

        $display("[TB] phase: random traffic");
        v_addr = 17'h10;
        r_req  = 1'b0;
        r_we   = 1'b0;
        r_addr = '0;
        r_wd   = '0;
        for (int n = 0; n < 400; n++) begin
            if ((n % 100) < 20 || $urandom_range(0, 3) == 0) v_addr = pick();
            v_en = ($urandom_range(0, 7) != 0);
            if (!r_req) begin
                r_req  = ($urandom_range(0, 1) == 1);
                r_we   = ($urandom_range(0, 1) == 1);
                r_addr = pick();
                r_wd   = {16'($urandom()), $urandom()};
            end
            applyStimulus(v_en, v_addr, r_req, r_we, r_addr, r_wd);
            if (owner == 2) r_req = 1'b0;
            endCycle();
            if (n == 200) begin
                doReset();
                r_req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
